// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared constants for the UART receive path: FSM state encoding,
//          oversampling geometry, majority-vote sample points and the
//          baud/sample-clock divider ratios used with a 50 MHz sysclk.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Receiver FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Frame / oversampling geometry
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  // Tick positions (within one bit period) of the three vote samples
  localparam int SAMPLE_A = 7;
  localparam int SAMPLE_B = 8;
  localparam int SAMPLE_C = 9;

  // sysclk cycles per sample tick for a 50 MHz sysclk
  localparam int DIV_9600   = 326;
  localparam int DIV_115200 = 27;

  // 2-of-3 majority
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_sync
// Brief  : Input conditioning for the UART receiver. Brings the asynchronous
//          rxd pin into the sysclk domain and turns the divider's sample_clk
//          level into a one-cycle tick on its rising edge.
// Ports  : sysclk     - system clock
//          rst_n      - asynchronous active-low reset
//          sample_clk - 16x sample clock level (already in sysclk domain)
//          rxd        - raw serial line, idle high
//          rxd_s      - synchronised serial line
//          tick       - one-sysclk pulse per sample_clk rising edge
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic sample_clk,
  input  logic rxd,
  output logic rxd_s,
  output logic tick
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sc_d;

  // Chain resets to the idle-high line level so no false start edge is seen
  // when reset is released.
  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) r_sync <= '1;
        else        r_sync <= rxd;
      end
    end else begin : g_sync_chain
      always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) r_sync <= '1;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
      end
    end
  endgenerate

  // Delayed copy resets high so a sample_clk already high at reset release
  // does not produce a tick.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) r_sc_d <= 1'b1;
    else        r_sc_d <= sample_clk;
  end

  assign rxd_s = r_sync[SYNC_STAGES-1];
  assign tick  = sample_clk & ~r_sc_d;

endmodule
`default_nettype wire

// File: rtl/uart_rx_oversample.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_oversample
// Brief  : 8N1 UART receiver running on sysclk, advanced by ticks derived
//          from the 16x sample clock. Each bit is decided by a 2-of-3 vote
//          around mid-bit. Bytes are delivered as single-cycle pulses.
// Ports  : sysclk     - system clock (50 MHz)
//          rst_n      - asynchronous active-low reset
//          sample_clk - 16x sample clock from the divider (used as a level)
//          rxd        - asynchronous serial line, idle high
//          rx_data    - last correctly received byte
//          rx_valid   - one-cycle pulse when rx_data is updated
//          frame_err  - one-cycle pulse when the stop bit votes low
//          busy       - high while a frame is in progress
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 sample_clk,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int c_TICK_W = $clog2(OVERSAMPLE);
  localparam int c_IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
  localparam logic [c_TICK_W-1:0] c_SMP_A     = c_TICK_W'(SAMPLE_A);
  localparam logic [c_TICK_W-1:0] c_SMP_B     = c_TICK_W'(SAMPLE_B);
  localparam logic [c_TICK_W-1:0] c_SMP_C     = c_TICK_W'(SAMPLE_C);
  localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DATA_BITS - 1);

  logic                 w_rxd_s;
  logic                 w_tick;
  logic                 w_vote;
  logic [c_TICK_W-1:0]  w_tick_nxt;

  logic [1:0]           r_state;
  logic [c_TICK_W-1:0]  r_tick_cnt;
  logic [c_IDX_W-1:0]   r_bit_idx;
  logic                 r_last_sample;
  logic                 r_smp_a;
  logic                 r_smp_b;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .sample_clk (sample_clk),
    .rxd        (rxd),
    .rxd_s      (w_rxd_s),
    .tick       (w_tick)
  );

  // Third sample is taken live at tick 9, so the vote is ready that same tick.
  assign w_vote     = majority3(r_smp_a, r_smp_b, w_rxd_s);
  assign w_tick_nxt = (r_tick_cnt == c_TICK_LAST) ? '0 : r_tick_cnt + 1'b1;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_tick_cnt    <= '0;
      r_bit_idx     <= '0;
      r_last_sample <= 1'b1;
      r_smp_a       <= 1'b1;
      r_smp_b       <= 1'b1;
      r_shift       <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_tick) begin
        r_last_sample <= w_rxd_s;
        if (r_tick_cnt == c_SMP_A) r_smp_a <= w_rxd_s;
        if (r_tick_cnt == c_SMP_B) r_smp_b <= w_rxd_s;

        case (r_state)
          IDLE: begin
            // Edge (not level) detect: a held-low break cannot retrigger.
            if (!w_rxd_s && r_last_sample) begin
              r_state    <= START;
              r_tick_cnt <= c_TICK_W'(1);
            end else begin
              r_tick_cnt <= '0;
            end
          end

          START: begin
            r_tick_cnt <= w_tick_nxt;
            if (r_tick_cnt == c_SMP_C && w_vote) begin
              r_state    <= IDLE;      // glitch, not a real start bit
              r_tick_cnt <= '0;
            end else if (r_tick_cnt == c_TICK_LAST) begin
              r_state   <= DATA;
              r_bit_idx <= '0;
            end
          end

          DATA: begin
            r_tick_cnt <= w_tick_nxt;
            if (r_tick_cnt == c_SMP_C)
              r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};   // LSB arrives first
            if (r_tick_cnt == c_TICK_LAST) begin
              r_bit_idx <= r_bit_idx + 1'b1;
              if (r_bit_idx == c_IDX_LAST) r_state <= STOP;
            end
          end

          STOP: begin
            r_tick_cnt <= w_tick_nxt;
            // Leave at mid-stop-bit so the next start edge is never missed.
            if (r_tick_cnt == c_SMP_C) begin
              r_state    <= IDLE;
              r_tick_cnt <= '0;
              if (w_vote) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
              end else begin
                r_frame_err <= 1'b1;
              end
            end
          end

          default: begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversample.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_oversample
// Brief  : Self-checking bench for uart_rx_oversample. Drives 8N1 frames on
//          rxd, records every output pulse, and compares against expected
//          bytes, pulse counts and timing windows derived from the frame
//          format. The 115200 divider ratio is used so frames are short.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_rx_oversample;
  import uart_pkg::*;

  localparam int DIV = DIV_115200;            // sysclk cycles per sample tick
  localparam int BIT = OVERSAMPLE_DEF * DIV;  // sysclk cycles per bit
  localparam int LAT = 153 * DIV;             // start-detect tick to rx_valid

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       sample_clk;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit sc_run      = 1'b1;
  int t_start     = 0;

  // Monitor records (written only by the monitor process)
  int         v_cyc[$];
  logic [7:0] v_dat[$];
  logic       v_busy[$];
  logic       v_pbusy[$];
  int         fe_cyc[$];
  int         busy_cycles = 0;
  bit         both_seen   = 1'b0;
  logic       prev_busy   = 1'b0;

  uart_rx_oversample dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .sample_clk (sample_clk),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #10 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Divider model: ~50% duty level, changed away from the active edge
  initial begin
    int sc_cnt;
    sc_cnt     = 0;
    sample_clk = 1'b0;
    forever begin
      @(negedge sysclk);
      if (sc_run) begin
        sc_cnt     = (sc_cnt == DIV - 1) ? 0 : sc_cnt + 1;
        sample_clk = (sc_cnt < (DIV + 1) / 2);
      end else begin
        sample_clk = 1'b0;
      end
    end
  end

  always @(negedge sysclk) begin
    if (rx_valid) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(rx_data);
      v_busy.push_back(busy);
      v_pbusy.push_back(prev_busy);
    end
    if (frame_err) fe_cyc.push_back(cyc);
    if (rx_valid && frame_err) both_seen = 1'b1;
    if (busy) busy_cycles = busy_cycles + 1;
    prev_busy = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // One 8N1 frame; glitch_bit >= 0 inverts that data bit briefly near mid-bit
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl,
                            input int stop_len, input int glitch_bit);
    t_start = cyc;
    rxd = 1'b0;
    drive(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      if (i == glitch_bit) begin
        drive(BIT / 2 + DIV / 2);
        rxd = ~d[i];
        drive(20);
        rxd = d[i];
        drive(BIT - BIT / 2 - DIV / 2 - 20);
      end else begin
        drive(BIT);
      end
    end
    rxd = stop_lvl;
    drive(stop_len);
    rxd = 1'b1;
  endtask

  // Exactly one good byte since the given record indices
  task automatic expect_rx(input string tag, input int vb, input int fb, input logic [7:0] exp);
    int d;
    check({tag, "_nvalid"}, v_cyc.size() - vb, 1);
    check({tag, "_nferr"}, fe_cyc.size() - fb, 0);
    if (v_cyc.size() > vb) begin
      check({tag, "_data"}, v_dat[vb], exp);
      check({tag, "_busy_at_valid"}, v_busy[vb], 0);
      check({tag, "_busy_before"}, v_pbusy[vb], 1);
      d = v_cyc[vb] - t_start;
      check({tag, "_latency_ok"}, (d >= LAT + 3 && d <= LAT + 34), 1);
    end
  endtask

  initial begin
    int         vb, fb, bc, gap;
    logic [7:0] c3;
    logic [7:0] d;
    logic       s;
    logic [7:0] exp_last;

    rst_n = 1'b0;
    rxd   = 1'b1;
    @(negedge sysclk);
    drive(5);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    drive(2 * BIT);
    check("post_rst_busy", busy, 0);

    // Single byte
    vb = v_cyc.size(); fb = fe_cyc.size();
    send_frame(8'h55, 1'b1, BIT, -1);
    drive(BIT);
    expect_rx("b55", vb, fb, 8'h55);

    // Back-to-back with a 1% short stop bit
    vb = v_cyc.size(); fb = fe_cyc.size();
    send_frame(8'hA5, 1'b1, BIT * 99 / 100, -1);
    send_frame(8'h3C, 1'b1, BIT, -1);
    drive(BIT);
    check("b2b_nvalid", v_cyc.size() - vb, 2);
    check("b2b_nferr", fe_cyc.size() - fb, 0);
    if (v_cyc.size() >= vb + 2) begin
      check("b2b_first", v_dat[vb], 8'hA5);
      check("b2b_second", v_dat[vb + 1], 8'h3C);
      check("b2b_spacing_ok",
            ((v_cyc[vb + 1] - v_cyc[vb]) >= 9 * BIT + BIT * 99 / 100 - 32) &&
            ((v_cyc[vb + 1] - v_cyc[vb]) <= 9 * BIT + BIT * 99 / 100 + 32), 1);
    end

    // Two-tick low glitch: false start
    vb = v_cyc.size(); fb = fe_cyc.size(); bc = busy_cycles;
    rxd = 1'b0;
    drive(2 * DIV);
    rxd = 1'b1;
    drive(20 * DIV);
    check("glitch_busy_seen", (busy_cycles - bc) > 0, 1);
    check("glitch_busy_end", busy, 0);
    check("glitch_nvalid", v_cyc.size() - vb, 0);
    check("glitch_nferr", fe_cyc.size() - fb, 0);

    // Stop bit low -> framing error, data held
    vb = v_cyc.size(); fb = fe_cyc.size();
    send_frame(8'hFF, 1'b0, BIT, -1);
    drive(BIT);
    check("ferr_nferr", fe_cyc.size() - fb, 1);
    check("ferr_nvalid", v_cyc.size() - vb, 0);
    check("ferr_rx_data_held", rx_data, 8'h3C);
    check("ferr_busy", busy, 0);
    vb = v_cyc.size(); fb = fe_cyc.size();
    send_frame(8'h12, 1'b1, BIT, -1);
    drive(BIT);
    expect_rx("b12", vb, fb, 8'h12);

    // Single-sample flip inside data bit 3 is outvoted
    vb = v_cyc.size(); fb = fe_cyc.size();
    send_frame(8'h81, 1'b1, BIT, 3);
    drive(BIT);
    expect_rx("b81_vote", vb, fb, 8'h81);

    // Reset during data bit 4 of 0xC3
    vb = v_cyc.size(); fb = fe_cyc.size();
    c3 = 8'hC3;
    rxd = 1'b0;
    drive(BIT);
    for (int i = 0; i < 4; i++) begin
      rxd = c3[i];
      drive(BIT);
    end
    rxd = c3[4];
    drive(BIT / 2);
    check("mid_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    rxd   = 1'b1;
    drive(2);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_frame_err", frame_err, 0);
    drive(8);
    rst_n = 1'b1;
    drive(2 * BIT);
    check("mid_rst_nvalid", v_cyc.size() - vb, 0);
    check("mid_rst_nferr", fe_cyc.size() - fb, 0);
    check("mid_rst_data_after", rx_data, 0);
    vb = v_cyc.size(); fb = fe_cyc.size();
    send_frame(8'h7E, 1'b1, BIT, -1);
    drive(BIT);
    expect_rx("b7E", vb, fb, 8'h7E);

    // Sample clock stopped: line activity must be ignored
    sc_run = 1'b0;
    drive(DIV);
    vb = v_cyc.size(); fb = fe_cyc.size(); bc = busy_cycles;
    rxd = 1'b0;
    drive(10 * DIV);
    rxd = 1'b1;
    drive(2 * DIV);
    check("noclk_busy", busy_cycles - bc, 0);
    check("noclk_nvalid", v_cyc.size() - vb, 0);
    check("noclk_nferr", fe_cyc.size() - fb, 0);
    sc_run = 1'b1;
    drive(BIT);

    // Random frames against the frame-level model
    exp_last = 8'h7E;
    for (int k = 0; k < 5; k++) begin
      d   = 8'($urandom);
      s   = ($urandom_range(0, 3) != 0);
      gap = BIT + $urandom_range(0, BIT);
      vb = v_cyc.size(); fb = fe_cyc.size();
      send_frame(d, s, BIT, -1);
      drive(gap);
      if (s) begin
        expect_rx($sformatf("rnd%0d", k), vb, fb, d);
        exp_last = d;
      end else begin
        check($sformatf("rnd%0d_nferr", k), fe_cyc.size() - fb, 1);
        check($sformatf("rnd%0d_nvalid", k), v_cyc.size() - vb, 0);
        check($sformatf("rnd%0d_held", k), rx_data, exp_last);
      end
    end

    check("never_valid_and_ferr", both_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
